// File: rtl/aes_pkg.sv
// Shared AES block constants and types for the CBC block packer.
package aes_pkg;
  localparam int AES_BLK_W     = 128;
  localparam int AES_BLK_BYTES = 16;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_PACK,
    ST_SEND,
    ST_WAIT_CT
  } aes_state_e;
endpackage

// File: rtl/aes_byte_packer.sv
// Collects bytes into a 128-bit block, first byte in the MSB lane.
// Clearing at block start leaves unfilled lanes zero for short blocks.
module aes_byte_packer
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr,
  input  logic [7:0]           i_byte,
  output logic [AES_BLK_W-1:0] o_blk,
  output logic [4:0]           o_cnt
);
  aes_blk_t   r_blk;
  logic [4:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else if (i_wr) begin
      for (int k = 0; k < AES_BLK_BYTES; k++) begin
        if (r_cnt == 5'(k)) r_blk[AES_BLK_W-1-8*k -: 8] <= i_byte;
      end
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_blk = r_blk;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/aes_cbc_block_packer.sv
// Byte stream to CBC-chained 128-bit plaintext blocks: skips a header,
// packs 16-byte blocks, XORs with IV/previous ciphertext, waits for the core.
module aes_cbc_block_packer
  import aes_pkg::*;
#(
  parameter int SKIP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic [SKIP_W-1:0]    cfg_skip,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_last,
  input  logic                 ct_valid,
  input  logic [AES_BLK_W-1:0] ct_data,
  output logic                 busy
);
  aes_state_e        r_state, w_next;
  logic [SKIP_W-1:0] r_skip;
  aes_blk_t          r_chain;
  logic              r_last;

  logic     w_xfer, w_wr, w_clr;
  aes_blk_t w_blk;
  logic [4:0] w_cnt;

  aes_byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_wr   (w_wr),
    .i_byte (in_data),
    .o_blk  (w_blk),
    .o_cnt  (w_cnt)
  );

  assign in_ready  = (r_state == ST_SKIP) || (r_state == ST_PACK);
  assign w_xfer    = in_valid && in_ready;
  assign blk_valid = (r_state == ST_SEND);
  assign busy      = (r_state != ST_IDLE);
  // Outputs held at zero outside SEND so idle/reset values are clean.
  assign blk_data  = blk_valid ? (w_blk ^ r_chain) : '0;
  assign blk_last  = blk_valid && r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr  = 1'b1;
          w_next = (cfg_skip != '0) ? ST_SKIP : ST_PACK;
        end
      end
      ST_SKIP: begin
        if (w_xfer) begin
          if (in_last)                    w_next = ST_IDLE;
          else if (r_skip == SKIP_W'(1))  w_next = ST_PACK;
        end
      end
      ST_PACK: begin
        if (w_xfer) begin
          w_wr = 1'b1;
          if (in_last || (w_cnt == 5'(AES_BLK_BYTES-1))) w_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (blk_ready) begin
          w_clr  = 1'b1;
          w_next = ST_WAIT_CT;
        end
      end
      ST_WAIT_CT: begin
        if (ct_valid) w_next = r_last ? ST_IDLE : ST_PACK;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skip  <= '0;
      r_chain <= '0;
      r_last  <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_skip  <= cfg_skip;
      r_chain <= cfg_iv;
      r_last  <= 1'b0;
    end else if (r_state == ST_SKIP && w_xfer) begin
      r_skip <= r_skip - SKIP_W'(1);
    end else if (r_state == ST_PACK && w_xfer && in_last) begin
      r_last <= 1'b1;
    end else if (r_state == ST_WAIT_CT && ct_valid) begin
      r_chain <= ct_data;
      r_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_cbc_block_packer.sv
// Directed bench for aes_cbc_block_packer with hand-computed expected blocks.
module tb_aes_cbc_block_packer;
  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, in_ready, in_last;
  logic [127:0] cfg_iv, blk_data, ct_data;
  logic [15:0]  cfg_skip;
  logic [7:0]   in_data;
  logic         blk_valid, blk_ready, blk_last, ct_valid, busy;

  int checks = 0;
  int errors = 0;

  aes_cbc_block_packer #(.SKIP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_iv(cfg_iv), .cfg_skip(cfg_skip),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .ct_valid(ct_valid), .ct_data(ct_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rdy"},  128'(in_ready), 128'(0));
    chk({tag, "_bv"},   128'(blk_valid), 128'(0));
    chk({tag, "_bl"},   128'(blk_last), 128'(0));
    chk({tag, "_bd"},   blk_data, 128'(0));
  endtask

  task automatic do_start(input logic [127:0] iv, input logic [15:0] skip);
    @(negedge clk);
    start = 1'b1; cfg_iv = iv; cfg_skip = skip;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("byte_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0; in_last = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic get_blk(input string tag, input logic [127:0] exp_d, input logic exp_l);
    int n = 0;
    @(negedge clk);
    while (!blk_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 128'(blk_valid), 128'(1));
    chk({tag, "_data"}, blk_data, exp_d);
    chk({tag, "_last"}, 128'(blk_last), 128'(exp_l));
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic ret_ct(input logic [127:0] ct);
    @(negedge clk);
    ct_valid = 1'b1; ct_data = ct;
    @(posedge clk); #1;
    ct_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_iv = '0; cfg_skip = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    blk_ready = 1'b0; ct_valid = 1'b0; ct_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;

    // Single full block, last on the 16th byte, zero IV.
    do_start('0, 16'd0);
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_rdy", 128'(in_ready), 128'(1));
    for (int i = 0; i < 16; i++) put_byte(8'(i), i == 15);
    chk("t1_lat", 128'(blk_valid), 128'(1));
    get_blk("t1", 128'h000102030405060708090A0B0C0D0E0F, 1'b1);
    @(negedge clk);
    chk("t1_wait_rdy", 128'(in_ready), 128'(0));
    ret_ct(128'h1234);
    @(negedge clk);
    chk("t1_done_busy", 128'(busy), 128'(0));

    // Skip 3 header bytes, all-ones IV.
    do_start({128{1'b1}}, 16'd3);
    chk("t2_skip_rdy", 128'(in_ready), 128'(1));
    for (int i = 0; i < 19; i++) put_byte(8'(8'hA0 + i), i == 18);
    chk("t2_lat", 128'(blk_valid), 128'(1));
    get_blk("t2", 128'h5C5B5A595857565554535251504F4E4D, 1'b1);
    ret_ct(128'h0);
    @(negedge clk);
    chk("t2_done_busy", 128'(busy), 128'(0));

    // Two blocks chained through ciphertext; stalled SEND with stray ct_valid.
    do_start('0, 16'd0);
    for (int i = 0; i < 16; i++) put_byte(8'h01, 1'b0);
    chk("t3_lat", 128'(blk_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h99;
      ct_valid = (i == 1); ct_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      chk("t3_hold_data", blk_data, {16{8'h01}});
      chk("t3_hold_last", 128'(blk_last), 128'(0));
      chk("t3_hold_rdy", 128'(in_ready), 128'(0));
    end
    @(negedge clk);
    ct_valid = 1'b0; in_valid = 1'b0;
    chk("t3_after_ct_data", blk_data, {16{8'h01}});
    chk("t3_after_ct_valid", 128'(blk_valid), 128'(1));
    get_blk("t3b1", {16{8'h01}}, 1'b0);
    ret_ct({16{8'h5A}});
    for (int i = 0; i < 4; i++) put_byte(8'h01, i == 3);
    get_blk("t3b2", 128'h5B5B5B5B_5A5A5A5A_5A5A5A5A_5A5A5A5A, 1'b1);
    ret_ct(128'h0);
    @(negedge clk);
    chk("t3_done_busy", 128'(busy), 128'(0));

    // Reset mid-message, then a fresh message.
    do_start({16{8'h11}}, 16'd0);
    for (int i = 0; i < 7; i++) put_byte(8'hEE, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("midrst");
    do_start('0, 16'd0);
    for (int i = 0; i < 16; i++) put_byte(8'(8'h10 + i), i == 15);
    get_blk("t4", 128'h101112131415161718191A1B1C1D1E1F, 1'b1);
    ret_ct(128'h0);

    // in_last inside the header; start while busy is ignored.
    do_start({16{8'h33}}, 16'd2);
    put_byte(8'h55, 1'b0);
    do_start('0, 16'd0);
    chk("t5_still_busy", 128'(busy), 128'(1));
    put_byte(8'h66, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_blk", 128'(blk_valid), 128'(0));
      chk("t5_idle", 128'(busy), 128'(0));
    end

    // skip=1 then in_last on the first packed byte: zero-filled block.
    do_start('0, 16'd1);
    put_byte(8'h77, 1'b0);
    put_byte(8'hC3, 1'b1);
    chk("t6_lat", 128'(blk_valid), 128'(1));
    get_blk("t6", 128'hC3000000_00000000_00000000_00000000, 1'b1);
    ret_ct(128'h0);
    @(negedge clk);
    chk("t6_done_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
